// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   XLEN   : core word width in bits
//   NBYTES : bytes per word; this is also the address step between words
//   IDX_W  : width of the byte-lane index inside a word
//   imem_loader_state_t : loader FSM states
package imem_loader_pkg;

  localparam int XLEN   = 32;
  localparam int NBYTES = XLEN / 8;
  localparam int IDX_W  = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } imem_loader_state_t;

endpackage : imem_loader_pkg

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into one XLEN-bit word.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the word buffer and reset the lane index (wins over load)
//   load       : write byte_in into lane [8*idx +: 8], then advance idx
//   byte_in    : incoming stream byte
//   word       : packed word; lanes not yet loaded read as zero
//   full       : the next load fills the top lane (idx == NBYTES-1)
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            load,
  input  logic [7:0]      byte_in,
  output logic [XLEN-1:0] word,
  output logic            full
);

  logic [IDX_W-1:0] idx;

  // NOTE: the word buffer is a handful of flops rather than a memory array,
  // so it is reset; this also makes mem_wdata read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (clear) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      word[8*idx +: 8] <= byte_in;
      // Wraps to zero after the top lane; the loader clears us before reuse.
      idx              <= idx + 1'b1;
    end
  end

  assign full = (idx == IDX_W'(NBYTES - 1));

endmodule : byte_packer

// File: rtl/imem_loader.sv
// Boot-time program loader for the instruction memory.
// Accepts bytes over a valid/ready link, packs them into XLEN-bit words and
// issues one single-cycle write per word at consecutive word addresses
// starting at BASE_ADDR. Writes beyond MEM_DEPTH words are suppressed and
// flagged as overflow.
//   start                      : begin (or restart) a load; honoured in IDLE/DONE
//   in_valid/in_data/in_last   : byte stream from the host link
//   in_ready                   : byte accepted when in_valid && in_ready
//   mem_we/mem_addr/mem_wdata  : instruction-memory write port
//   busy, done, overflow, word_count : status of the current load
// Every output is decoded from registers only.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = XLEN,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [XLEN-1:0]              mem_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow,
  output logic [$clog2(MEM_DEPTH):0]   word_count
);

  localparam int CNT_W = $clog2(MEM_DEPTH) + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(NBYTES);

  imem_loader_state_t    state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ovf_q;
  logic                  last_q;

  logic                  pk_clear;
  logic                  pk_load;
  logic                  pk_full;
  logic [XLEN-1:0]       pk_word;
  logic                  room;

  assign room = (cnt_q < DEPTH_C);

  byte_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (pk_clear),
    .load    (pk_load),
    .byte_in (in_data),
    .word    (pk_word),
    .full    (pk_full)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pk_clear = 1'b0;
    pk_load  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pk_clear = 1'b1;
          state_d  = RECV;
        end
      end
      RECV: begin
        // in_ready is high throughout RECV, so in_valid alone is the handshake.
        if (in_valid) begin
          pk_load = 1'b1;
          if (pk_full || in_last) state_d = WRITE;
        end
      end
      WRITE: begin
        if (room) begin
          pk_clear = 1'b1;
          state_d  = last_q ? DONE : RECV;
        end else begin
          // Image larger than memory: drop the word and stall the stream.
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE || state_q == DONE) && start) begin
        addr_q <= BASE_ADDR;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
        last_q <= 1'b0;
      end else if (state_q == RECV && in_valid && (pk_full || in_last)) begin
        last_q <= in_last;
      end else if (state_q == WRITE) begin
        if (room) begin
          addr_q <= addr_q + STEP_C;
          cnt_q  <= cnt_q + 1'b1;
        end else begin
          ovf_q  <= 1'b1;
        end
      end
    end
  end

  assign in_ready   = (state_q == RECV);
  assign busy       = (state_q == RECV) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign mem_we     = (state_q == WRITE) && room;
  assign mem_addr   = addr_q;
  assign mem_wdata  = pk_word;
  assign overflow   = ovf_q;
  assign word_count = cnt_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Three instances share clk/rst_n:
//   0: defaults (MEM_DEPTH=1024, BASE_ADDR=0)
//   1: MEM_DEPTH=4 (overflow behaviour)
//   2: BASE_ADDR=0x100 (start-ignore and reload behaviour)
// Drivers push expected writes into per-instance queues; a monitor pops and
// compares on every mem_we.
module tb_imem_loader;

  localparam int N = 3;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start    [N];
  logic        in_valid [N];
  logic [7:0]  in_data  [N];
  logic        in_last  [N];
  wire         in_ready [N];
  wire         mem_we   [N];
  wire  [31:0] mem_addr [N];
  wire  [31:0] mem_wdata[N];
  wire         busy     [N];
  wire         done     [N];
  wire         overflow [N];
  wire  [10:0] wc       [N];

  int checks = 0;
  int errors = 0;
  wr_t exp_q [N][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int          DEPTH = (g == 1) ? 4 : 1024;
    localparam logic [31:0] BASE  = (g == 2) ? 32'h100 : 32'h0;
    localparam int          CW    = $clog2(DEPTH) + 1;
    wire [CW-1:0] wc_l;
    imem_loader #(.ADDR_WIDTH(32), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[g]),
      .in_valid   (in_valid[g]),
      .in_data    (in_data[g]),
      .in_last    (in_last[g]),
      .in_ready   (in_ready[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .overflow   (overflow[g]),
      .word_count (wc_l)
    );
    assign wc[g] = 11'(wc_l);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input int d, input logic [31:0] a, input logic [31:0] w);
    exp_q[d].push_back('{a: a, d: w});
  endtask

  // Monitor: every write must match the head of the queue and must occur
  // while in_ready is low.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (mem_we[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write[%0d]: got 0x%0h@0x%0h, expected no write",
                   i, mem_wdata[i], mem_addr[i]);
        end else begin
          wr_t e;
          e = exp_q[i].pop_front();
          check($sformatf("write_addr[%0d]", i), 64'(mem_addr[i]), 64'(e.a));
          check($sformatf("write_data[%0d]", i), 64'(mem_wdata[i]), 64'(e.d));
        end
        check($sformatf("in_ready_in_write[%0d]", i), 64'(in_ready[i]), 64'd0);
      end
    end
  end

  task automatic pulse_start(input int d);
    @(negedge clk) start[d] = 1'b1;
    @(negedge clk) start[d] = 1'b0;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input bit last, input bit gap);
    int n = 0;
    if (gap) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    in_last[d]  = last;
    while (in_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check($sformatf("handshake_timeout[%0d]", d), 64'd1, 64'd0);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic send_stream(input int d, input logic [7:0] bs[$], input bit gap);
    for (int i = 0; i < bs.size(); i++) send_byte(d, bs[i], i == bs.size() - 1, gap);
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    while (done[d] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("done[%0d]", d), 64'(done[d]), 64'd1);
  endtask

  initial begin
    logic [7:0] bs[$];
    int         n;

    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0; in_last[i] = 1'b0;
    end

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready[0]), 64'd0);
    check("rst_mem_we",   64'(mem_we[0]),   64'd0);
    check("rst_busy",     64'(busy[0]),     64'd0);
    check("rst_done",     64'(done[0]),     64'd0);
    check("rst_overflow", 64'(overflow[0]), 64'd0);
    check("rst_addr",     64'(mem_addr[0]), 64'd0);
    check("rst_wdata",    64'(mem_wdata[0]),64'd0);
    check("rst_wc",       64'(wc[0]),       64'd0);
    check("rst_addr_base",64'(mem_addr[2]), 64'h100);
    rst_n = 1'b1;

    // Two full words.
    pulse_start(0);
    check("busy_after_start",     64'(busy[0]),     64'd1);
    check("in_ready_after_start", 64'(in_ready[0]), 64'd1);
    expect_wr(0, 32'h0, 32'h0000_0013);
    expect_wr(0, 32'h4, 32'h0010_0093);
    bs = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_stream(0, bs, 1'b0);
    wait_done(0);
    check("t1_wc",       64'(wc[0]),       64'd2);
    check("t1_overflow", 64'(overflow[0]), 64'd0);
    check("t1_busy",     64'(busy[0]),     64'd0);

    // Partial final word, zero-filled upper lanes.
    pulse_start(0);
    check("t2_done_cleared", 64'(done[0]), 64'd0);
    expect_wr(0, 32'h0, 32'hDDCC_BBAA);
    expect_wr(0, 32'h4, 32'h0000_2211);
    bs = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_stream(0, bs, 1'b0);
    wait_done(0);
    check("t2_wc", 64'(wc[0]), 64'd2);

    // Same 8 bytes with random gaps on in_valid.
    pulse_start(0);
    expect_wr(0, 32'h0, 32'h0000_0013);
    expect_wr(0, 32'h4, 32'h0010_0093);
    bs = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    send_stream(0, bs, 1'b1);
    wait_done(0);
    check("t3_wc", 64'(wc[0]), 64'd2);

    // Overflow on the MEM_DEPTH=4 instance: 5 words offered, 4 written.
    pulse_start(1);
    bs = {};
    for (int i = 0; i < 20; i++) bs.push_back(8'(i + 1));
    expect_wr(1, 32'h0, 32'h0403_0201);
    expect_wr(1, 32'h4, 32'h0807_0605);
    expect_wr(1, 32'h8, 32'h0C0B_0A09);
    expect_wr(1, 32'hC, 32'h100F_0E0D);
    send_stream(1, bs, 1'b0);
    wait_done(1);
    check("ovf_flag", 64'(overflow[1]), 64'd1);
    check("ovf_wc",   64'(wc[1]),       64'd4);
    // Further bytes must stall.
    n = 0;
    @(negedge clk) begin in_valid[1] = 1'b1; in_data[1] = 8'h55; end
    repeat (10) begin
      @(negedge clk);
      if (in_ready[1] === 1'b1) n++;
    end
    in_valid[1] = 1'b0;
    check("ovf_in_ready_held", 64'(n), 64'd0);

    // Restart after overflow clears done/overflow/word_count.
    pulse_start(1);
    check("ovf_restart_done", 64'(done[1]),     64'd0);
    check("ovf_restart_flag", 64'(overflow[1]), 64'd0);
    check("ovf_restart_wc",   64'(wc[1]),       64'd0);
    expect_wr(1, 32'h0, 32'hA4A3_A2A1);
    bs = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_stream(1, bs, 1'b0);
    wait_done(1);
    check("ovf_restart_wc_end", 64'(wc[1]), 64'd1);

    // Reset mid-load: partial word discarded, no write.
    pulse_start(0);
    send_byte(0, 8'hEE, 1'b0, 1'b0);
    send_byte(0, 8'hFF, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready[0]), 64'd0);
    check("midrst_busy",     64'(busy[0]),     64'd0);
    check("midrst_done",     64'(done[0]),     64'd0);
    check("midrst_we",       64'(mem_we[0]),   64'd0);
    check("midrst_addr",     64'(mem_addr[0]), 64'd0);
    check("midrst_wdata",    64'(mem_wdata[0]),64'd0);
    check("midrst_wc",       64'(wc[0]),       64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_start(0);
    expect_wr(0, 32'h0, 32'h0403_0201);
    bs = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_stream(0, bs, 1'b0);
    wait_done(0);
    check("midrst_after_wc", 64'(wc[0]), 64'd1);

    // BASE_ADDR=0x100: start in RECV is ignored.
    pulse_start(2);
    send_byte(2, 8'h11, 1'b0, 1'b0);
    send_byte(2, 8'h22, 1'b0, 1'b0);
    pulse_start(2);
    check("base_busy_after_ignored_start", 64'(busy[2]), 64'd1);
    expect_wr(2, 32'h100, 32'h4433_2211);
    send_byte(2, 8'h33, 1'b0, 1'b0);
    send_byte(2, 8'h44, 1'b1, 1'b0);
    wait_done(2);
    check("base_wc", 64'(wc[2]), 64'd1);
    check("base_next_addr", 64'(mem_addr[2]), 64'h104);

    // Reload after DONE restarts from BASE_ADDR.
    pulse_start(2);
    check("base_reload_done", 64'(done[2]),     64'd0);
    check("base_reload_addr", 64'(mem_addr[2]), 64'h100);
    check("base_reload_ovf",  64'(overflow[2]), 64'd0);
    expect_wr(2, 32'h100, 32'h0000_00C1);
    expect_wr(2, 32'h104, 32'h0000_0000);
    bs = '{8'hC1, 8'h00, 8'h00, 8'h00, 8'h00};
    send_stream(2, bs, 1'b0);
    wait_done(2);
    check("base_reload_wc", 64'(wc[2]), 64'd2);

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("missing_writes[%0d]", i), 64'(exp_q[i].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_imem_loader
